// File: rtl/mprj_wb_pkg.sv
// rtl/mprj_wb_pkg.sv - register offsets, bit positions, reset values and FSM states
package mprj_wb_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_SCRATCH = 2'd2;
  localparam logic [1:0] REG_DATA    = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_FLUSH_BIT  = 2;

  localparam int STATUS_FULL_BIT  = 7;
  localparam int STATUS_EMPTY_BIT = 8;
  localparam int STATUS_OVF_BIT   = 9;

  localparam logic        CTRL_EN_RESET     = 1'b0;
  localparam logic        CTRL_IRQ_EN_RESET = 1'b0;
  localparam logic [31:0] SCRATCH_RESET     = 32'h0;
  localparam logic        OVF_RESET         = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } wb_state_e;

  function automatic logic [31:0] sel_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mprj_wb_sync_fifo.sv
// rtl/mprj_wb_sync_fifo.sv - power-of-two synchronous FIFO with flush and same-cycle push/pop
module mprj_wb_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mprj_wb_responder.sv
// rtl/mprj_wb_responder.sv - Wishbone register slave with push FIFO; IRQ via MPRJ_WB_RESPONDER_IRQ_EN
module mprj_wb_responder
  import mprj_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          IRQ_THRESH = 4
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        fifo_rd_valid,
  output logic [31:0] fifo_rd_data,
  input  logic        fifo_rd_ready,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_state_e   state, state_next;
  logic        hit, req, take;
  logic        req_we;
  logic [1:0]  req_reg;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;

  logic        ctrl_en;
  logic        ctrl_irq_en;
  logic [31:0] scratch;
  logic        ovf;

  logic        wr;
  logic        push, pop, flush;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0] fifo_head;
  logic        unused_adr_bits;

  assign unused_adr_bits = ^wb_adr_i[1:0];

  assign hit = (wb_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req = wb_cyc_i && wb_stb_i && hit;

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) state <= ST_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    wb_ack_o   = 1'b0;
    take       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          take       = 1'b1;
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        wb_ack_o   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (wb_adr_i[3:2])
      REG_CTRL: begin
        rd_mux[CTRL_EN_BIT]     = ctrl_en;
        rd_mux[CTRL_IRQ_EN_BIT] = ctrl_irq_en;
      end
      REG_STATUS: begin
        rd_mux[6:0]              = 7'(fifo_count);
        rd_mux[STATUS_FULL_BIT]  = fifo_full;
        rd_mux[STATUS_EMPTY_BIT] = fifo_empty;
        rd_mux[STATUS_OVF_BIT]   = ovf;
      end
      REG_SCRATCH: rd_mux = scratch;
      REG_DATA:    rd_mux = fifo_empty ? 32'h0 : fifo_head;
      default:     rd_mux = '0;
    endcase
  end

  // Request is latched at sampling so writes commit from stable values during ACK;
  // rdata_q reloads every cycle, so it is nonzero only in the ACK cycle of a read.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      req_we  <= 1'b0;
      req_reg <= '0;
      req_dat <= '0;
      req_sel <= '0;
      rdata_q <= '0;
    end else begin
      rdata_q <= (take && !wb_we_i) ? rd_mux : 32'h0;
      if (take) begin
        req_we  <= wb_we_i;
        req_reg <= wb_adr_i[3:2];
        req_dat <= wb_dat_i;
        req_sel <= wb_sel_i;
      end
    end
  end

  assign wb_dat_o = rdata_q;

  assign wr    = (state == ST_ACK) && req_we;
  assign push  = wr && (req_reg == REG_DATA) && ctrl_en;
  assign pop   = fifo_rd_valid && fifo_rd_ready;
  assign flush = wr && (req_reg == REG_CTRL) && req_dat[CTRL_FLUSH_BIT];

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      ctrl_en <= CTRL_EN_RESET;
      scratch <= SCRATCH_RESET;
      ovf     <= OVF_RESET;
    end else begin
      if (wr && req_reg == REG_CTRL)    ctrl_en <= req_dat[CTRL_EN_BIT];
      if (wr && req_reg == REG_SCRATCH) scratch <= sel_merge(scratch, req_dat, req_sel);
      if (wr && req_reg == REG_STATUS && req_dat[STATUS_OVF_BIT]) ovf <= 1'b0;
      else if (push && fifo_full && !pop)                          ovf <= 1'b1;
    end
  end

`ifdef MPRJ_WB_RESPONDER_IRQ_EN
  logic irq_q;

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      ctrl_irq_en <= CTRL_IRQ_EN_RESET;
      irq_q       <= 1'b0;
    end else begin
      if (wr && req_reg == REG_CTRL) ctrl_irq_en <= req_dat[CTRL_IRQ_EN_BIT];
      irq_q <= ctrl_irq_en && ((int'(fifo_count) >= IRQ_THRESH) || ovf);
    end
  end

  assign irq_o = irq_q;
`else
  assign ctrl_irq_en = 1'b0;
  assign irq_o       = 1'b0;
`endif

  mprj_wb_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (core_clk),
    .rst_n     (core_rstn),
    .push      (push),
    .push_data (req_dat),
    .pop       (pop),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign fifo_rd_valid = ctrl_en && !fifo_empty;
  assign fifo_rd_data  = fifo_rd_valid ? fifo_head : 32'h0;

endmodule

// File: tb/tb_mprj_wb_responder.sv
// tb/tb_mprj_wb_responder.sv - randomized self-checking bench against a transaction-level model
module tb_mprj_wb_responder;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int          DEPTH  = 8;
  localparam int          THRESH = 4;

  logic        core_clk = 1'b0;
  logic        core_rstn = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [31:0] wb_adr_i = 32'h0, wb_dat_i = 32'h0;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        fifo_rd_valid;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_ready = 1'b0;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  logic        m_en, m_irq_en, m_ovf;
  logic [31:0] m_scratch;
  logic [31:0] q[$];
  logic [31:0] rd;

  always #5 core_clk = ~core_clk;

  mprj_wb_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .IRQ_THRESH(THRESH)) dut (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .fifo_rd_valid(fifo_rd_valid), .fifo_rd_data(fifo_rd_data), .fifo_rd_ready(fifo_rd_ready),
    .irq_o(irq_o)
  );

  task automatic m_reset();
    m_en = 0; m_irq_en = 0; m_ovf = 0; m_scratch = 0; q.delete();
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0;
    s[6:0] = 7'(q.size());
    s[7]   = (q.size() == DEPTH);
    s[8]   = (q.size() == 0);
    s[9]   = m_ovf;
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] r);
    case (r)
      2'd0: return {30'h0, m_irq_en, m_en};
      2'd1: return m_status();
      2'd2: return m_scratch;
      default: return (q.size() != 0) ? q[0] : 32'h0;
    endcase
  endfunction

  function automatic logic m_cond();
`ifdef MPRJ_WB_RESPONDER_IRQ_EN
    return m_irq_en && ((q.size() >= THRESH) || m_ovf);
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_commit(input logic we_c, input logic [1:0] r, input logic [31:0] d,
                          input logic [3:0] s, input bit do_pop);
    if (do_pop) void'(q.pop_front());
    if (!we_c) return;
    case (r)
      2'd0: begin
        m_en = d[0];
`ifdef MPRJ_WB_RESPONDER_IRQ_EN
        m_irq_en = d[1];
`endif
        if (d[2]) q.delete();
      end
      2'd1: if (d[9]) m_ovf = 0;
      2'd2: for (int i = 0; i < 4; i++) if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
      default: begin
        if (m_en) begin
          if (q.size() < DEPTH) q.push_back(d);
          else m_ovf = 1;
        end
      end
    endcase
  endtask

  // One bus access: drive, expect ack one cycle after sampling, commit, then settle a cycle.
  task automatic xact(input logic we_c, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit pop_req, output logic [31:0] rdata);
    bit hit;
    bit prev_cond;
    bit do_pop;
    logic [31:0] exp_rd;
    hit = (a[31:4] == BASE[31:4]);
    @(negedge core_clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we_c; wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
    exp_rd = m_read(a[3:2]);
    @(negedge core_clk);
    checks++;
    if (wb_ack_o !== hit) begin
      errors++; $display("FAIL ack_latency: ack=%0b expected %0b adr=%h", wb_ack_o, hit, a);
    end
    rdata = wb_dat_o;
    if (hit && !we_c) begin
      checks++;
      if (wb_dat_o !== exp_rd) begin
        errors++; $display("FAIL read_data: got %h expected %h adr=%h", wb_dat_o, exp_rd, a);
      end
    end
    prev_cond = m_cond();
    do_pop = pop_req && m_en && (q.size() != 0);
    fifo_rd_ready = pop_req;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    @(negedge core_clk);
    fifo_rd_ready = 0;
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++; $display("FAIL ack_single: ack=%0b expected 0", wb_ack_o);
    end
    checks++;
    if (irq_o !== prev_cond) begin
      errors++; $display("FAIL irq_lag: irq=%0b expected %0b", irq_o, prev_cond);
    end
    m_commit(hit && we_c, a[3:2], d, s, do_pop);
    @(negedge core_clk);
    checks++;
    if (irq_o !== m_cond()) begin
      errors++; $display("FAIL irq_level: irq=%0b expected %0b", irq_o, m_cond());
    end
    checks++;
    if (fifo_rd_valid !== (m_en && q.size() != 0) ||
        fifo_rd_data !== ((m_en && q.size() != 0) ? q[0] : 32'h0)) begin
      errors++;
      $display("FAIL fifo_head: valid=%0b data=%h expected valid=%0b size=%0d",
               fifo_rd_valid, fifo_rd_data, m_en && q.size() != 0, q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge core_clk);
    checks++;
    if ({wb_ack_o, wb_dat_o, irq_o, fifo_rd_valid, fifo_rd_data} !== 67'h0) begin
      errors++; $display("FAIL reset_outputs: ack=%0b dat=%h irq=%0b valid=%0b data=%h expected all 0",
                         wb_ack_o, wb_dat_o, irq_o, fifo_rd_valid, fifo_rd_data);
    end
    core_rstn = 1; m_reset();
    xact(0, BASE + 32'h4, 0, 4'hF, 0, rd);
    checks++;
    if (rd !== 32'h100) begin
      errors++; $display("FAIL reset_status: got %h expected 00000100", rd);
    end
    xact(0, BASE + 32'h0, 0, 4'hF, 0, rd);
    xact(0, BASE + 32'h8, 0, 4'hF, 0, rd);
    xact(0, BASE + 32'hC, 0, 4'hF, 0, rd);
  endtask

  task automatic test_ctrl();
    xact(1, BASE + 32'h0, 32'h1, 4'hF, 0, rd);
    xact(0, BASE + 32'h0, 0, 4'hF, 0, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL ctrl_readback: got %h expected 00000001", rd);
    end
  endtask

  task automatic test_scratch();
    xact(1, BASE + 32'h8, 32'h0, 4'hF, 0, rd);
    xact(1, BASE + 32'h8, 32'hAABB_CCDD, 4'b0101, 0, rd);
    xact(0, BASE + 32'hA, 0, 4'hF, 0, rd);
    checks++;
    if (rd !== 32'h00BB_00DD) begin
      errors++; $display("FAIL scratch_sel: got %h expected 00bb00dd", rd);
    end
  endtask

  task automatic test_overflow();
    xact(1, BASE + 32'h0, 32'h5, 4'hF, 0, rd);
    for (int i = 0; i < 9; i++) xact(1, BASE + 32'hC, $urandom, 4'h0, 0, rd);
    xact(0, BASE + 32'h4, 0, 4'hF, 0, rd);
    checks++;
    if (rd !== 32'h288) begin
      errors++; $display("FAIL ovf_status: got %h expected 00000288", rd);
    end
    xact(1, BASE + 32'h4, 32'h200, 4'hF, 0, rd);
    xact(0, BASE + 32'h4, 0, 4'hF, 0, rd);
    checks++;
    if (rd !== 32'h088) begin
      errors++; $display("FAIL ovf_clear: got %h expected 00000088", rd);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] second;
    second = q[1];
    xact(1, BASE + 32'hC, 32'hC0DE_0009, 4'hF, 1, rd);
    checks++;
    if (fifo_rd_data !== second) begin
      errors++; $display("FAIL head_advance: got %h expected %h", fifo_rd_data, second);
    end
    xact(0, BASE + 32'h4, 0, 4'hF, 0, rd);
    checks++;
    if (rd !== 32'h088) begin
      errors++; $display("FAIL full_push_pop: got %h expected 00000088", rd);
    end
  endtask

  task automatic test_irq();
    logic exp_irq;
`ifdef MPRJ_WB_RESPONDER_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    xact(1, BASE + 32'h0, 32'h7, 4'hF, 0, rd);
    for (int i = 0; i < 4; i++) xact(1, BASE + 32'hC, $urandom, 4'hF, 0, rd);
    checks++;
    if (irq_o !== exp_irq) begin
      errors++; $display("FAIL irq_rise: irq=%0b expected %0b", irq_o, exp_irq);
    end
    xact(1, BASE + 32'h0, 32'h7, 4'hF, 0, rd);
    checks++;
    if (irq_o !== 1'b0) begin
      errors++; $display("FAIL irq_flush: irq=%0b expected 0", irq_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int n = 0; n < 80; n++) begin
      d = $urandom;
      case ($urandom_range(0, 9))
        0: xact(1, BASE + 32'h0, {29'h0, ($urandom_range(0, 5) == 0), d[1], ($urandom_range(0, 3) != 0)},
                4'hF, $urandom_range(0, 2) == 0, rd);
        1: xact(1, BASE + 32'h4, d, 4'hF, $urandom_range(0, 2) == 0, rd);
        2: xact(1, BASE + 32'h8, d, 4'($urandom_range(0, 15)), 0, rd);
        3, 4, 5: xact(1, BASE + 32'hC, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0, rd);
        6: xact(0, BASE + {28'h0, 4'($urandom_range(0, 15))}, 0, 4'hF, 0, rd);
        7: xact(0, BASE + 32'hC, 0, 4'hF, $urandom_range(0, 1) == 0, rd);
        8: xact($urandom_range(0, 1) == 1, BASE + 32'h10 + (32'($urandom_range(0, 255)) << 4), d, 4'hF,
                $urandom_range(0, 2) == 0, rd);
        default: xact(0, BASE + 32'h4, 0, 4'hF, 0, rd);
      endcase
    end
  endtask

  task automatic test_reset_midop();
    xact(0, BASE + 32'h10, 0, 4'hF, 0, rd);
    xact(1, BASE + 32'h8, 32'h1234_5678, 4'hF, 0, rd);
    xact(1, BASE + 32'h0, 32'h7, 4'hF, 0, rd);
    for (int i = 0; i < 4; i++) xact(1, BASE + 32'hC, $urandom | 32'h1, 4'hF, 0, rd);
    @(negedge core_clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = BASE + 32'h8; wb_sel_i = 4'hF;
    @(negedge core_clk);
    checks++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h1234_5678) begin
      errors++; $display("FAIL midop_ack: ack=%0b dat=%h expected 1 12345678", wb_ack_o, wb_dat_o);
    end
    core_rstn = 0;
    #1;
    checks++;
    if ({wb_ack_o, wb_dat_o, irq_o, fifo_rd_valid, fifo_rd_data} !== 67'h0) begin
      errors++; $display("FAIL midop_reset: ack=%0b dat=%h irq=%0b valid=%0b data=%h expected all 0",
                         wb_ack_o, wb_dat_o, irq_o, fifo_rd_valid, fifo_rd_data);
    end
    wb_cyc_i = 0; wb_stb_i = 0;
    @(negedge core_clk);
    core_rstn = 1; m_reset();
    xact(0, BASE + 32'h8, 0, 4'hF, 0, rd);
    xact(0, BASE + 32'h4, 0, 4'hF, 0, rd);
    checks++;
    if (rd !== 32'h100) begin
      errors++; $display("FAIL midop_status: got %h expected 00000100", rd);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_ctrl();
    test_scratch();
    test_overflow();
    test_full_push_pop();
    test_irq();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mprj_wb_responder.md
MPRJ_WB_RESPONDER -- requirements
Module: mprj_wb_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: base of the 16-byte register window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: push-FIFO entries, a power of two from 2 to 64.
REQ-003 SHALL have parameter IRQ_THRESH, default 4: FIFO occupancy at or above which the IRQ condition holds.
REQ-004 SHALL use a single clock and an asynchronous active-low reset; all logic is clocked on the rising edge of core_clk.
REQ-005 Port list, in order:
- core_clk  in  1  clock.
- core_rstn  in  1  asynchronous active-low reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte lanes.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_ack_o  out  1  acknowledge.
- wb_dat_o  out  32  read data.
- fifo_rd_valid  out  1  FIFO head valid to user logic.
- fifo_rd_data  out  32  FIFO head data.
- fifo_rd_ready  in  1  user logic pops the head.
- irq_o  out  1  level interrupt to the management core.

Function
REQ-006 SHALL decode a hit when wb_adr_i[31:4] equals BASE_ADDR[31:4]; wb_adr_i[3:2] selects the register; wb_adr_i[1:0] is ignored.
REQ-007 SHALL implement a two-state FSM:
- IDLE: wb_cyc_i && wb_stb_i && hit moves to ACK.
- ACK: wb_ack_o=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-008 SHALL give ack latency of exactly 1 cycle after the request is sampled; a strobe held after ack starts a new transaction.
REQ-009 SHALL never assert wb_ack_o on an address miss, or while wb_cyc_i=0 at sampling.
REQ-010 SHALL commit write side effects on the cycle wb_ack_o is high, and drive registered read data on wb_dat_o in that same cycle; wb_dat_o=0 when wb_ack_o=0.
REQ-011 Register map:
- 0x0 CTRL, RW: bit0 en; bit1 irq_en; bit2 flush, write-1 self-clearing, reads 0.
- 0x4 STATUS, RO except bit9: [6:0] count, bit7 full, bit8 empty, bit9 ovf (sticky, write-1-to-clear).
- 0x8 SCRATCH, RW, honouring wb_sel_i per byte.
- 0xC DATA: a write pushes wb_dat_i (wb_sel_i ignored); a read returns the FIFO head without popping, or 0 when empty.
REQ-012 SHALL drop a DATA write while en=0, with no count or ovf change.
REQ-013 SHALL drop a DATA write while full and set ovf, still acknowledging the write.
REQ-014 SHALL assert fifo_rd_valid = en && !empty; a pop occurs on fifo_rd_valid && fifo_rd_ready.
REQ-015 SHALL leave count unchanged, and apply both operations, when a push and a pop occur in the same cycle; when the FIFO is full at that cycle, the push is accepted and ovf is not set.
REQ-016 SHALL let flush take priority over a same-cycle push and pop, giving count=0, empty=1 and pointers=0 on the next cycle; ovf is unaffected.
REQ-017 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.
REQ-018 SHALL keep count FIFO_DEPTH-limited, with count width of $clog2(FIFO_DEPTH)+1 zero-extended to 7 bits in STATUS.

Reset
REQ-019 SHALL, while core_rstn=0, force:
- FSM to IDLE;
- wb_ack_o=0, wb_dat_o=0, irq_o=0, fifo_rd_valid=0, fifo_rd_data=0;
- CTRL=0 and SCRATCH=0;
- FIFO empty with ovf=0.
REQ-020 SHALL abandon, without ack, a transaction in progress when reset is asserted mid-operation.

Configuration
REQ-021 SHALL, with MPRJ_WB_RESPONDER_IRQ_EN defined, drive irq_o registered as irq_en && (count >= IRQ_THRESH || ovf), one cycle after the condition.
REQ-022 SHALL, without MPRJ_WB_RESPONDER_IRQ_EN, tie irq_o to 0, not implement CTRL bit1 (writes ignored, reads 0), and leave all other behaviour unchanged.

Structure
REQ-023 SHALL place register offsets, CTRL/STATUS bit positions and the 0 reset values in shared package mprj_wb_pkg.
REQ-024 SHALL implement the FIFO in sub-module mprj_wb_sync_fifo, with push, pop, flush, full, empty, count and head ports.

Verification
REQ-025 Write 0x1 to CTRL, then read it back → ack exactly 1 cycle after stb; read data 0x1; wb_ack_o low in the following cycle.
REQ-026 Write 0xAABBCCDD to SCRATCH with sel=4'b0101, starting from 0 → read back 0x00BB00DD.
REQ-027 With en=1, push 9 words into the default FIFO with fifo_rd_ready=0 → STATUS reads count=8, full=1, ovf=1; 9 acks; writing 0x200 to STATUS clears ovf.
REQ-028 With the FIFO full, push and assert fifo_rd_ready in the same cycle → count stays 8, ovf stays 0, head advances.
REQ-029 With IRQ_EN defined, irq_en=1 and 4 pushes → irq_o rises 1 cycle after the 4th ack; a flush write drops irq_o 2 cycles later; without the macro, irq_o stays 0 throughout.
REQ-030 Access to BASE_ADDR+0x10, then reset asserted during the ACK state → no ack on the miss; outputs 0 immediately on reset.
